// File: rtl/scan_pkg.sv
// Shared definitions for the scan sequencer: state encoding and index geometry.
package scan_pkg;

  localparam int IDX_W   = 2;
  localparam int NUM_IDX = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_t;

endpackage

// File: rtl/scan_seq_if.sv
// Control and select bundle between a scan controller and the scan sequencer.
interface scan_seq_if #(
  parameter int DWELL_W = 16
) ();

  logic               start;
  logic               stop;
  logic               cont;
  logic [DWELL_W-1:0] dwell;
  logic               sel_a;
  logic               sel_b;
  logic               dec_en;
  logic               frame_done;
  logic               busy;

  modport master (
    output start, stop, cont, dwell,
    input  sel_a, sel_b, dec_en, frame_done, busy
  );

  modport slave (
    input  start, stop, cont, dwell,
    output sel_a, sel_b, dec_en, frame_done, busy
  );

endinterface

// File: rtl/scan_seq.sv
// Round-robin scan sequencer: walks index 0..3 with a programmable dwell and a
// fixed blanking gap, driving the select/enable pins of the 2-to-4 decoder.
module scan_seq
  import scan_pkg::*;
#(
  parameter int DWELL_W   = 16,
  parameter int BLANK_CYC = 4
) (
  input  logic      clk,
  input  logic      rst,
  scan_seq_if.slave bus
);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_IDX - 1);
  localparam bit                 HAS_BLANK = (BLANK_CYC > 0);
  localparam logic [DWELL_W-1:0] BLANK_M1  = HAS_BLANK ? DWELL_W'(BLANK_CYC - 1) : '0;

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [DWELL_W-1:0] r_cnt;
  logic               r_fd;
  logic               r_dec_en;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic               w_fd_nxt;
  logic               w_adv;
  logic               w_dec_en_nxt;
  logic               w_busy_nxt;
  logic [DWELL_W-1:0] w_dwell_m1;

  // A dwell of zero still gives one active cycle.
  assign w_dwell_m1 = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;

  // State register; enable/busy are registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_fd     <= 1'b0;
      r_dec_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fd     <= w_fd_nxt;
      r_dec_en <= w_dec_en_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_fd_nxt    = 1'b0;
    w_adv       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_ACTIVE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = w_dwell_m1;
        end
      end
      ST_ACTIVE: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else if (HAS_BLANK) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = BLANK_M1;
        end else begin
          w_adv = 1'b1;
        end
      end
      ST_BLANK: begin
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        else             w_adv     = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Advance out of the current index; cont only matters after the last one.
    if (w_adv) begin
      if (r_idx != LAST_IDX) begin
        w_state_nxt = ST_ACTIVE;
        w_idx_nxt   = r_idx + 1'b1;
        w_cnt_nxt   = w_dwell_m1;
      end else begin
        w_fd_nxt = 1'b1;
        if (bus.cont) begin
          w_state_nxt = ST_ACTIVE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = w_dwell_m1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    end

    // Abort wins over everything, including a same-cycle start or frame end.
    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_fd_nxt    = 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    w_dec_en_nxt = (w_state_nxt == ST_ACTIVE);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
  end

  assign bus.sel_a      = r_idx[1];
  assign bus.sel_b      = r_idx[0];
  assign bus.dec_en     = r_dec_en;
  assign bus.frame_done = r_fd;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_scan_seq.sv
// Scoreboard bench: two sequencers (blanking 2 and blanking 0) run the same
// scenarios; expected per-cycle traces come from a frame-level model.
module tb_scan_seq;

  localparam int DW = 16;

  typedef struct packed {
    logic [1:0] idx;
    logic       en;
    logic       fd;
    logic       busy;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start_v [2];
  logic          stop_v  [2];
  logic          cont_v  [2];
  logic [DW-1:0] dwell_v [2];

  scan_seq_if #(.DWELL_W(DW)) if0 ();
  scan_seq_if #(.DWELL_W(DW)) if1 ();

  assign if0.start = start_v[0];
  assign if0.stop  = stop_v[0];
  assign if0.cont  = cont_v[0];
  assign if0.dwell = dwell_v[0];
  assign if1.start = start_v[1];
  assign if1.stop  = stop_v[1];
  assign if1.cont  = cont_v[1];
  assign if1.dwell = dwell_v[1];

  scan_seq #(.DWELL_W(DW), .BLANK_CYC(2)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  scan_seq #(.DWELL_W(DW), .BLANK_CYC(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  exp_t act [2];
  assign act[0] = {if0.sel_a, if0.sel_b, if0.dec_en, if0.frame_done, if0.busy};
  assign act[1] = {if1.sel_a, if1.sel_b, if1.dec_en, if1.frame_done, if1.busy};

  exp_t       q [2][$];
  int         errors = 0;
  int         checks = 0;
  logic [1:0] last_idx [2];

  function automatic exp_t mk(input int idx, input bit en, input bit fd, input bit busy);
    exp_t x;
    x.idx = 2'(idx); x.en = en; x.fd = fd; x.busy = busy;
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with an outstanding expectation is compared.
  always @(negedge clk) begin
    exp_t e;
    for (int u = 0; u < 2; u++) begin
      if (q[u].size() > 0) begin
        e = q[u].pop_front();
        checks++;
        if (act[u] !== e) begin
          errors++;
          $display("FAIL dut%0d trace @%0t: got idx=%0d en=%b fd=%b busy=%b, want idx=%0d en=%b fd=%b busy=%b",
                   u, $time, act[u].idx, act[u].en, act[u].fd, act[u].busy,
                   e.idx, e.en, e.fd, e.busy);
        end
      end
    end
  end

  // Builds the expected trace of one scan from the frame rules, then drives it.
  // Cycle 0 is the idle cycle in which start is presented. nfr=0 means endless
  // (the scan is then ended by stop_at or rst_at).
  task automatic run_scan(input int u, input int blank, input int dws[$], input int nfr,
                          input int stop_at, input int rst_at, input int busy_start_at);
    exp_t e[$];
    int   gi[$];
    int   cut, i, d, g;
    bit   fd_pend, done;
    exp_t x;
    cut     = (stop_at >= 0) ? stop_at : rst_at;
    i       = 0;
    fd_pend = 1'b0;
    done    = 1'b0;
    e.push_back(mk(last_idx[u], 0, 0, 0));
    gi.push_back(-1);
    while (!done && (cut < 0 || e.size() <= cut + 1)) begin
      d = dws[i % dws.size()];
      if (d < 1) d = 1;
      for (int k = 0; k < d; k++) begin
        e.push_back(mk(i % 4, 1, fd_pend && k == 0, 1));
        gi.push_back(i);
      end
      fd_pend = 1'b0;
      for (int k = 0; k < blank; k++) begin
        e.push_back(mk(i % 4, 0, 0, 1));
        gi.push_back(i);
      end
      if (i % 4 == 3) begin
        if (nfr == 0 || i / 4 < nfr - 1) fd_pend = 1'b1;
        else begin
          e.push_back(mk(3, 0, 1, 0));
          gi.push_back(i);
          done = 1'b1;
        end
      end
      i++;
    end
    if (cut >= 0) begin
      while (e.size() > cut + 1) begin
        void'(e.pop_back());
        void'(gi.pop_back());
      end
      x = mk((stop_at >= 0) ? int'(e[cut].idx) : 0, 0, 0, 0);
      e.push_back(x);
      gi.push_back(gi[gi.size()-1]);
    end
    x = mk(e[e.size()-1].idx, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      e.push_back(x);
      gi.push_back(gi[gi.size()-1]);
    end
    last_idx[u] = x.idx;
    foreach (e[c]) q[u].push_back(e[c]);

    // dwell always presents the value for the next reload, so it changes
    // mid-index and must only be picked up at the reload edge.
    foreach (e[c]) begin
      g = gi[c];
      start_v[u] = (c == 0) || (c == busy_start_at);
      stop_v[u]  = (c == stop_at);
      if (u == 0) rst = (c == rst_at);
      dwell_v[u] = DW'(dws[(g + 1) % dws.size()]);
      cont_v[u]  = (nfr == 0) || (g / 4 < nfr - 1);
      step();
    end
    start_v[u] = 1'b0;
    stop_v[u]  = 1'b0;
    if (u == 0) rst = 1'b0;
  endtask

  initial begin
    int dl[$];
    int nf;
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0; stop_v[u] = 1'b0; cont_v[u] = 1'b0; dwell_v[u] = '0;
      last_idx[u] = 2'd0;
    end
    rst = 1'b1;
    step();
    step();

    // Single frame, dwell 3.
    fork
      run_scan(0, 2, '{3}, 1, -1, -1, -1);
      run_scan(1, 0, '{3}, 1, -1, -1, -1);
    join
    // Continuous wrap over 3 frames, dwell 2, with an ignored start while busy.
    fork
      run_scan(0, 2, '{2}, 3, -1, -1, 5);
      run_scan(1, 0, '{2}, 3, -1, -1, 5);
    join
    // Dwell 0 on index 0, then 5 on index 1 while the input already shows 1.
    fork
      run_scan(0, 2, '{0, 5, 1, 3}, 1, -1, -1, -1);
      run_scan(1, 0, '{0, 5, 1, 3}, 1, -1, -1, -1);
    join
    // Stop at the very end of index 3 (last blank / last active cycle).
    fork
      run_scan(0, 2, '{3}, 0, 20, -1, -1);
      run_scan(1, 0, '{3}, 0, 12, -1, -1);
    join
    // Start and stop together in idle.
    fork
      run_scan(0, 2, '{3}, 1, 0, -1, -1);
      run_scan(1, 0, '{3}, 1, 0, -1, -1);
    join
    // Reset during index 2 active.
    fork
      run_scan(0, 2, '{6}, 0, -1, 17, -1);
      run_scan(1, 0, '{6}, 0, -1, 17, -1);
    join
    // Randomized dwell lists and frame counts.
    for (int r = 0; r < 5; r++) begin
      dl = {};
      for (int k = 0; k < 4; k++) dl.push_back(int'($urandom_range(0, 4)));
      nf = int'($urandom_range(1, 2));
      fork
        run_scan(0, 2, dl, nf, -1, -1, 3);
        run_scan(1, 0, dl, nf, -1, -1, 3);
      join
    end

    step();
    step();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (q[u].size() != 0) begin
        errors++;
        $display("FAIL dut%0d drain: %0d expectations left, want 0", u, q[u].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
